processor_status_register: RTL



---
 rtl/processor_status_register.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/processor_status_register.sv
// -----------------------------------------------------------------------------
// processor_status_register
//
// Processor status register (P) for the cpu6502 core. Holds the C, Z, I, D,
// V and N flags. Each flag is loaded on the rising clock edge from the
// highest-priority active load strobe, or holds when none of its strobes is
// active. The formatted P byte is available both as a registered view (o_p,
// B bit reads 0) and as the byte to push onto the data bus (o_p_db, B bit
// taken from i_brk). A small two-state machine produces the interrupt mask
// seen by interrupt recognition. That mask lags CLI/SEI/PLP changes of I
// until the next instruction boundary, but follows interrupt entry at once.
//
// Ports
//   i_clk          core clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_db[7:0]      internal data bus (flag source for loads, Z/N tests)
//   i_acr, i_avr   ALU carry / overflow outputs
//   i_ir5          instruction bit 5 (1 = SEx, 0 = CLx)
//   i_acr_c, i_db0_c, i_ir5_c    C <- ACR / DB[0] / IR5
//   i_dbz_z, i_db1_z             Z <- (DB==0) / DB[1]
//   i_1_i, i_db2_i, i_ir5_i      I <- 1 / DB[2] / IR5
//   i_db3_d, i_ir5_d             D <- DB[3] / IR5
//   i_avr_v, i_db6_v, i_0_v      V <- AVR / DB[6] / 0
//   i_db7_n                      N <- DB[7]
//   i_instr_done   last cycle of the current instruction
//   i_brk          B bit for the pushed byte
//   o_p[7:0]       {N,V,1,0,D,I,Z,C}
//   o_p_db[7:0]    {N,V,1,i_brk,D,I,Z,C}
//   o_irq_mask     I flag as seen by interrupt recognition
// -----------------------------------------------------------------------------
module processor_status_register (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_db,
    input  logic       i_acr,
    input  logic       i_avr,
    input  logic       i_ir5,
    input  logic       i_acr_c,
    input  logic       i_db0_c,
    input  logic       i_ir5_c,
    input  logic       i_dbz_z,
    input  logic       i_db1_z,
    input  logic       i_1_i,
    input  logic       i_db2_i,
    input  logic       i_ir5_i,
    input  logic       i_db3_d,
    input  logic       i_ir5_d,
    input  logic       i_avr_v,
    input  logic       i_db6_v,
    input  logic       i_0_v,
    input  logic       i_db7_n,
    input  logic       i_instr_done,
    input  logic       i_brk,
    output logic [7:0] o_p,
    output logic [7:0] o_p_db,
    output logic       o_irq_mask
);

    localparam logic [0:0] TRACK = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic c_reg, c_next;
    logic z_reg, z_next;
    logic i_reg, i_next;
    logic d_reg, d_next;
    logic v_reg, v_next;
    logic n_reg, n_next;

    logic [0:0] state_reg, state_next;
    logic       mask_reg, mask_next;

    // I changed by an instruction (CLI/SEI/PLP) rather than interrupt entry;
    // such changes must not reach the mask until the instruction boundary.
    logic       i_soft_change;

    // ---------------------------------------------------------------------
    // Flag next-state: priority chains, hold when no strobe is active
    // ---------------------------------------------------------------------
    always_comb begin
        c_next = c_reg;
        if (i_acr_c)      c_next = i_acr;
        else if (i_db0_c) c_next = i_db[0];
        else if (i_ir5_c) c_next = i_ir5;

        z_next = z_reg;
        if (i_dbz_z)      z_next = (i_db == 8'h00);
        else if (i_db1_z) z_next = i_db[1];

        i_next = i_reg;
        if (i_1_i)        i_next = 1'b1;
        else if (i_db2_i) i_next = i_db[2];
        else if (i_ir5_i) i_next = i_ir5;

        d_next = d_reg;
        if (i_db3_d)      d_next = i_db[3];
        else if (i_ir5_d) d_next = i_ir5;

        v_next = v_reg;
        if (i_avr_v)      v_next = i_avr;
        else if (i_db6_v) v_next = i_db[6];
        else if (i_0_v)   v_next = 1'b0;

        n_next = n_reg;
        if (i_db7_n)      n_next = i_db[7];
    end

    assign i_soft_change = ~i_1_i & (i_db2_i | i_ir5_i) & (i_next != i_reg);

    // ---------------------------------------------------------------------
    // Interrupt mask state machine
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        if (i_1_i) begin
            // Interrupt entry: mask follows I on the same edge, from any state.
            state_next = TRACK;
            mask_next  = 1'b1;
        end else begin
            case (state_reg)
                TRACK: begin
                    if (i_soft_change) begin
                        state_next = HOLD;   // keep the old mask value
                    end else begin
                        mask_next  = i_reg;
                    end
                end
                HOLD: begin
                    if (i_instr_done) begin
                        mask_next = i_reg;
                        // A fresh change on the boundary edge starts a new delay.
                        if (!i_soft_change) begin
                            state_next = TRACK;
                        end
                    end
                end
                default: begin
                    state_next = TRACK;
                    mask_next  = i_reg;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            c_reg     <= 1'b0;
            z_reg     <= 1'b0;
            i_reg     <= 1'b1;
            d_reg     <= 1'b0;
            v_reg     <= 1'b0;
            n_reg     <= 1'b0;
            state_reg <= TRACK;
            mask_reg  <= 1'b1;
        end else begin
            c_reg     <= c_next;
            z_reg     <= z_next;
            i_reg     <= i_next;
            d_reg     <= d_next;
            v_reg     <= v_next;
            n_reg     <= n_next;
            state_reg <= state_next;
            mask_reg  <= mask_next;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: bit 5 always reads 1; B exists only in the pushed byte
    // ---------------------------------------------------------------------
    assign o_p        = {n_reg, v_reg, 1'b1, 1'b0,  d_reg, i_reg, z_reg, c_reg};
    assign o_p_db     = {n_reg, v_reg, 1'b1, i_brk, d_reg, i_reg, z_reg, c_reg};
    assign o_irq_mask = mask_reg;

endmodule
